product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter N_ACC, default 4, giving the number of products summed per result (legal range 1..255).
REQ-002 The block SHALL have parameter ACC_W, default 72, giving the signed accumulator width (minimum 64).
REQ-003 The block SHALL have the following ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  a product is present.
- in_ready  output  1  block accepts a product this cycle.
- product  input  64  signed two's-complement product from the multiplier stage.
- clear  input  1  synchronous abort; discards the partial sum.
- out_valid  output  1  a result is held.
- out_ready  input  1  consumer accepts the result.
- acc_out  output  ACC_W  signed accumulated result.
- ovf  output  1  the result overflowed ACC_W.

Function
REQ-004 The FSM SHALL have exactly three states:
- IDLE: no product accepted yet.
- ACCUM: count products accepted, 0 < count < N_ACC.
- HOLD: result presented.
REQ-005 A product SHALL be accepted only on a cycle where in_valid && in_ready.
REQ-006 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-007 An accepted product SHALL be sign-extended to ACC_W and added to the running sum in the same cycle; the first product after IDLE replaces the sum rather than adding to it.
REQ-008 On acceptance of the N_ACC-th product, the state SHALL go to HOLD next cycle with out_valid=1, and acc_out SHALL hold the final sum (latency: 1 cycle after the last accepted product).
REQ-009 In HOLD, acc_out, ovf and out_valid SHALL remain stable until out_ready=1.
REQ-010 When out_valid && out_ready, the state SHALL go to IDLE.
REQ-011 There SHALL be no bypass: a new product is accepted no earlier than the cycle after the handshake.
REQ-012 With N_ACC=1, every accepted product SHALL go directly IDLE->HOLD.
REQ-013 Signed overflow of any addition within a group SHALL set an ovf flag for that group.
REQ-014 The ovf flag SHALL be cleared when the next group starts.
REQ-015 clear=1 SHALL force IDLE, zero the sum, count and ovf, and deassert out_valid next cycle.
REQ-016 clear SHALL take priority over a simultaneous product acceptance or output handshake.
REQ-017 A product with in_valid=1 while in_ready=0 SHALL NOT be consumed or altered.
REQ-018 The product counter SHALL be 8 bits and SHALL never exceed N_ACC.

Reset
REQ-019 Asserting rst=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, acc_out=0, ovf=0 and count=0, including mid-group or in HOLD.
REQ-020 Deassertion of rst SHALL be synchronised externally; the block SHALL operate from the first rising edge after rst=1.

Configuration
REQ-021 When macro PRODUCT_ACC_SATURATE_EN is defined, an overflowing addition SHALL clamp the sum to the signed ACC_W maximum or minimum.
REQ-022 Once clamped, further additions SHALL continue from the clamped value, and ovf SHALL still be set.
REQ-023 When PRODUCT_ACC_SATURATE_EN is not defined, the sum SHALL wrap modulo 2^ACC_W and ovf SHALL be set.

Structure
REQ-024 The package mult_pkg SHALL hold:
- the FSM state enum (IDLE, ACCUM, HOLD);
- constant PROD_W=64;
- the default ACC_W and N_ACC values.
REQ-025 The signed add-with-overflow/saturate logic SHALL be a sub-module acc_add (inputs a, b; outputs sum, ovf) that is purely combinational.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- N_ACC=4; products 10, -3, 7, 100 back-to-back -> out_valid 1 cycle after the 4th, acc_out=114, ovf=0.
- out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, acc_out stable at 114, no product lost; the product is accepted the cycle after the handshake.
- ACC_W=64; products 0x7FFF_FFFF_FFFF_FFFF and 1:
  - with PRODUCT_ACC_SATURATE_EN -> acc_out=0x7FFF_FFFF_FFFF_FFFF, ovf=1;
  - without -> acc_out=0x8000_0000_0000_0000, ovf=1.
- Two products accepted, then clear=1 with in_valid=1 in the same cycle -> IDLE, sum 0, the next 4 products -20, -20, 5, 5 give acc_out=-30.
- rst=0 asynchronously in HOLD -> out_valid=0 and acc_out=0 before the next clk edge.
- N_ACC=1; product -1 -> acc_out=all ones (ACC_W bits), ovf=0, 1-cycle latency.

Source files
------------

// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int PROD_W        = 64;
  localparam int ACC_W_DEFAULT = 72;
  localparam int N_ACC_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/product_accumulator_acc_add.sv
// ============================================================================
// Module      : acc_add
// Description : Combinational signed adder with overflow detect; clamps to
//               the signed range when PRODUCT_ACC_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_add #(
  parameter int ACC_W = 72
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] w_raw;

  assign w_raw = a + b;
  // Overflow only when both operands share a sign the result does not.
  assign ovf   = (a[ACC_W-1] == b[ACC_W-1]) && (w_raw[ACC_W-1] != a[ACC_W-1]);

`ifdef PRODUCT_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] c_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  assign sum = ovf ? (a[ACC_W-1] ? c_MIN : c_MAX) : w_raw;
`else
  assign sum = w_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// Module      : product_accumulator
// Description : Sums N_ACC signed 64-bit products into an ACC_W result with
//               overflow flag. Optional macro: PRODUCT_ACC_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator
  import mult_pkg::*;
#(
  parameter int N_ACC = N_ACC_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  localparam logic [7:0] c_N_ACC = 8'(N_ACC);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_count;
  logic [7:0]       w_count_next;
  logic [ACC_W-1:0] r_sum;
  logic [ACC_W-1:0] w_sum_next;
  logic             r_ovf;
  logic             w_ovf_next;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_add_a;
  logic [ACC_W-1:0] w_add_sum;
  logic             w_add_ovf;
  logic             w_accept;

  assign in_ready   = (r_state != HOLD);
  assign w_accept   = in_valid && in_ready;
  assign w_prod_ext = ACC_W'($signed(product));
  // Starting from zero makes the first product of a group replace the sum.
  assign w_add_a    = (r_state == IDLE) ? '0 : r_sum;

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .a   (w_add_a),
    .b   (w_prod_ext),
    .sum (w_add_sum),
    .ovf (w_add_ovf)
  );

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_sum_next   = r_sum;
    w_ovf_next   = r_ovf;
    if (clear) begin
      w_state_next = IDLE;
      w_count_next = 8'd0;
      w_sum_next   = '0;
      w_ovf_next   = 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            w_count_next = (r_state == IDLE) ? 8'd1 : r_count + 8'd1;
            w_sum_next   = w_add_sum;
            w_ovf_next   = (r_state == IDLE) ? w_add_ovf : (r_ovf | w_add_ovf);
            w_state_next = (w_count_next >= c_N_ACC) ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_state_next = IDLE;
            w_count_next = 8'd0;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_count_next = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= 8'd0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_sum   <= w_sum_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign out_valid = (r_state == HOLD);
  assign acc_out   = r_sum;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// Module      : tb_product_accumulator
// Description : Directed self-checking bench for product_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Instance A: N_ACC=4, ACC_W=72
  logic        a_in_valid, a_in_ready, a_clear, a_out_valid, a_out_ready, a_ovf;
  logic [63:0] a_product;
  logic [71:0] a_acc_out;
  // Instance B: N_ACC=2, ACC_W=64
  logic        b_in_valid, b_in_ready, b_clear, b_out_valid, b_out_ready, b_ovf;
  logic [63:0] b_product;
  logic [63:0] b_acc_out;
  // Instance C: N_ACC=1, ACC_W=72
  logic        c_in_valid, c_in_ready, c_clear, c_out_valid, c_out_ready, c_ovf;
  logic [63:0] c_product;
  logic [71:0] c_acc_out;

  product_accumulator #(.N_ACC(4), .ACC_W(72)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .product(a_product), .clear(a_clear), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .acc_out(a_acc_out), .ovf(a_ovf)
  );

  product_accumulator #(.N_ACC(2), .ACC_W(64)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .product(b_product), .clear(b_clear), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .acc_out(b_acc_out), .ovf(b_ovf)
  );

  product_accumulator #(.N_ACC(1), .ACC_W(72)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .product(c_product), .clear(c_clear), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .acc_out(c_acc_out), .ovf(c_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    a_in_valid = 0; a_clear = 0; a_out_ready = 0; a_product = '0;
    b_in_valid = 0; b_clear = 0; b_out_ready = 0; b_product = '0;
    c_in_valid = 0; c_clear = 0; c_out_ready = 0; c_product = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_acc_out !== 72'd0 || a_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: got rdy=%b vld=%b acc=%h ovf=%b, expected 1 0 0 0",
               a_in_ready, a_out_valid, a_acc_out, a_ovf);
    end
    checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_acc_out !== 64'd0 || b_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: got rdy=%b vld=%b acc=%h ovf=%b, expected 1 0 0 0",
               b_in_ready, b_out_valid, b_acc_out, b_ovf);
    end
  endtask

  task automatic test_back_to_back();
    a_in_valid = 1; a_product = 64'd10;
    @(negedge clk); a_product = -64'sd3;
    @(negedge clk); a_product = 64'd7;
    @(negedge clk); a_product = 64'd100;
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_early_valid: got out_valid=%b expected 0", a_out_valid);
    end
    @(negedge clk);
    // Product 50 stays offered through the HOLD phase.
    a_product = 64'd50;
    checks++;
    if (a_out_valid !== 1'b1 || a_acc_out !== 72'd114 || a_ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_result: got vld=%b acc=%0d ovf=%b, expected 1 114 0",
               a_out_valid, $signed(a_acc_out), a_ovf);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_acc_out !== 72'd114) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got rdy=%b vld=%b acc=%0d, expected 0 1 114",
                 i, a_in_ready, a_out_valid, $signed(a_acc_out));
      end
      @(negedge clk);
    end
    a_out_ready = 1;
    @(negedge clk);
    a_out_ready = 0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL handshake_idle: got vld=%b rdy=%b, expected 0 1", a_out_valid, a_in_ready);
    end
    @(negedge clk); a_product = 64'd1;
    @(negedge clk); a_product = 64'd2;
    @(negedge clk); a_product = 64'd3;
    @(negedge clk); a_in_valid = 0;
    checks++;
    if (a_out_valid !== 1'b1 || a_acc_out !== 72'd56 || a_ovf !== 1'b0) begin
      failures++;
      $display("FAIL no_loss_sum: got vld=%b acc=%0d ovf=%b, expected 1 56 0",
               a_out_valid, $signed(a_acc_out), a_ovf);
    end
    a_out_ready = 1;
    @(negedge clk);
    a_out_ready = 0;
  endtask

  task automatic test_clear();
    logic [71:0] exp;
    a_in_valid = 1; a_product = 64'd7;
    @(negedge clk); a_product = 64'd8;
    @(negedge clk); a_clear = 1; a_product = 64'd99;
    @(negedge clk); a_clear = 0; a_in_valid = 0;
    checks++;
    if (a_out_valid !== 1'b0 || a_acc_out !== 72'd0 || a_ovf !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_state: got vld=%b acc=%h ovf=%b rdy=%b, expected 0 0 0 1",
               a_out_valid, a_acc_out, a_ovf, a_in_ready);
    end
    a_in_valid = 1; a_product = -64'sd20;
    @(negedge clk); a_product = -64'sd20;
    @(negedge clk); a_product = 64'd5;
    @(negedge clk); a_product = 64'd5;
    @(negedge clk); a_in_valid = 0;
    exp = 72'(-30);
    checks++;
    if (a_out_valid !== 1'b1 || a_acc_out !== exp || a_ovf !== 1'b0) begin
      failures++;
      $display("FAIL clear_next_group: got vld=%b acc=%h ovf=%b, expected 1 %h 0",
               a_out_valid, a_acc_out, a_ovf, exp);
    end
    a_out_ready = 1;
    @(negedge clk);
    a_out_ready = 0;
  endtask

  task automatic test_async_reset();
    a_in_valid = 1; a_product = 64'd1;
    repeat (4) @(negedge clk);
    a_in_valid = 0;
    checks++;
    if (a_out_valid !== 1'b1 || a_acc_out !== 72'd4) begin
      failures++;
      $display("FAIL pre_reset_hold: got vld=%b acc=%0d, expected 1 4", a_out_valid, $signed(a_acc_out));
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_acc_out !== 72'd0 || a_ovf !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got vld=%b acc=%h ovf=%b rdy=%b, expected 0 0 0 1",
               a_out_valid, a_acc_out, a_ovf, a_in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [63:0] exp;
`ifdef PRODUCT_ACC_SATURATE_EN
    exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    exp = 64'h8000_0000_0000_0000;
`endif
    b_in_valid = 1; b_product = 64'h7FFF_FFFF_FFFF_FFFF;
    @(negedge clk); b_product = 64'd1;
    @(negedge clk); b_in_valid = 0;
    checks++;
    if (b_out_valid !== 1'b1 || b_acc_out !== exp || b_ovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow: got vld=%b acc=%h ovf=%b, expected 1 %h 1",
               b_out_valid, b_acc_out, b_ovf, exp);
    end
    b_out_ready = 1;
    @(negedge clk);
    b_out_ready = 0;
    b_in_valid = 1; b_product = 64'd3;
    @(negedge clk); b_product = 64'd4;
    @(negedge clk); b_in_valid = 0;
    checks++;
    if (b_out_valid !== 1'b1 || b_acc_out !== 64'd7 || b_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_cleared: got vld=%b acc=%h ovf=%b, expected 1 7 0",
               b_out_valid, b_acc_out, b_ovf);
    end
    b_out_ready = 1;
    @(negedge clk);
    b_out_ready = 0;
  endtask

  task automatic test_single();
    logic [71:0] exp;
    exp = '1;
    checks++;
    if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_idle: got vld=%b rdy=%b, expected 0 1", c_out_valid, c_in_ready);
    end
    c_in_valid = 1; c_product = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); c_in_valid = 0;
    checks++;
    if (c_out_valid !== 1'b1 || c_acc_out !== exp || c_ovf !== 1'b0) begin
      failures++;
      $display("FAIL single_result: got vld=%b acc=%h ovf=%b, expected 1 %h 0",
               c_out_valid, c_acc_out, c_ovf, exp);
    end
    c_out_ready = 1;
    @(negedge clk);
    c_out_ready = 0;
    checks++;
    if (c_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_release: got vld=%b expected 0", c_out_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_overflow();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
